// File: rtl/anc_output_mixer.sv
// anc_output_mixer: pairs a delayed/scaled ambient sample with a music sample and
// outputs music - gain*ambient, saturated to 16 bits. A per-pair gain ramp fades
// cancellation in and out. Three-state flow IDLE -> MULT -> SUM, one pair per 3 cycles.
// Optional build macro CLIP_COUNT_EN adds clip_count_out, a saturating count of clipped outputs.
module anc_output_mixer #(
  parameter int GAIN_SHIFT = 6,
  parameter int RAMP_EVERY = 1
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic               anc_en_in,
  input  logic               ambient_valid_in,
  input  logic signed [15:0] ambient_in,
  input  logic               music_valid_in,
  input  logic signed [15:0] music_in,
  output logic               done_out,
  output logic signed [15:0] signal_out,
  output logic               clip_out,
  output logic               overrun_out
`ifdef CLIP_COUNT_EN
  ,
  output logic [15:0]        clip_count_out
`endif
);

  localparam int GAIN_W = GAIN_SHIFT + 1;
  localparam int PROD_W = 16 + GAIN_SHIFT + 2;
  localparam int CNT_W  = (RAMP_EVERY > 1) ? $clog2(RAMP_EVERY) : 1;
  localparam logic [GAIN_W-1:0] GAIN_FULL = GAIN_W'(1 << GAIN_SHIFT);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(RAMP_EVERY - 1);

  typedef enum logic [1:0] {IDLE, MULT, SUM} state_t;

  state_t state, state_next;

  logic               amb_flag, mus_flag;
  logic signed [15:0] amb_hold, mus_hold;
  logic               consume;

  logic [GAIN_W-1:0]  gain;
  logic [CNT_W-1:0]   ramp_cnt;

  logic signed [15:0]       amb_p0, mus_p0;
  logic [GAIN_W-1:0]        gain_p0;
  logic signed [15:0]       mus_p1;
  logic signed [PROD_W-1:0] prod_p1;

  logic signed [PROD_W-1:0] amb_ext, gain_ext, prod_c, diff_c;
  logic [16:0]              sat_c;

  // Saturate the difference to 16 bits; bit 16 of the result flags a clip.
  // The value range never exceeds 17 signed bits since gain <= 2^GAIN_SHIFT.
  function automatic logic [16:0] sat16(input logic signed [PROD_W-1:0] d);
    if (d > PROD_W'(32767))
      return {1'b1, 16'h7FFF};
    else if (d < -PROD_W'(32768))
      return {1'b1, 16'h8000};
    else
      return {1'b0, d[15:0]};
  endfunction

  assign consume = (state == IDLE) && amb_flag && mus_flag;

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (reset_in) state <= IDLE;
    else          state <= state_next;
  end

  // FSM next state: one cycle each in MULT and SUM
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (amb_flag && mus_flag) state_next = MULT;
      MULT:    state_next = SUM;
      SUM:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Input capture flags and sticky overrun; a strobe beats the consume clear
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      amb_flag    <= 1'b0;
      mus_flag    <= 1'b0;
      overrun_out <= 1'b0;
    end else begin
      if (ambient_valid_in)     amb_flag <= 1'b1;
      else if (consume)         amb_flag <= 1'b0;
      if (music_valid_in)       mus_flag <= 1'b1;
      else if (consume)         mus_flag <= 1'b0;
      if ((ambient_valid_in && amb_flag && !consume) ||
          (music_valid_in && mus_flag && !consume))
        overrun_out <= 1'b1;
    end
  end

  // Input hold registers always take the newest sample
  always_ff @(posedge clk_in) begin
    if (ambient_valid_in) amb_hold <= ambient_in;
    if (music_valid_in)   mus_hold <= music_in;
  end

  // Gain ramp: steps once every RAMP_EVERY consumed pairs, clamped at 0 and full scale
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      gain     <= '0;
      ramp_cnt <= '0;
    end else if (consume) begin
      if (ramp_cnt == CNT_LAST) begin
        ramp_cnt <= '0;
        if (anc_en_in && (gain < GAIN_FULL))
          gain <= gain + GAIN_W'(1);
        else if (!anc_en_in && (gain != '0))
          gain <= gain - GAIN_W'(1);
      end else begin
        ramp_cnt <= ramp_cnt + CNT_W'(1);
      end
    end
  end

  // ---- stage p0: working copy of the pair and the gain in force at consumption
  always_ff @(posedge clk_in) begin
    if (consume) begin
      amb_p0  <= amb_hold;
      mus_p0  <= mus_hold;
      gain_p0 <= gain;
    end
  end

  assign amb_ext  = PROD_W'(amb_p0);
  assign gain_ext = PROD_W'($signed({1'b0, gain_p0}));
  assign prod_c   = amb_ext * gain_ext;

  // ---- stage p1: registered product during MULT
  always_ff @(posedge clk_in) begin
    if (state == MULT) begin
      prod_p1 <= prod_c;
      mus_p1  <= mus_p0;
    end
  end

  // Arithmetic shift floors toward -inf before the subtraction
  assign diff_c = PROD_W'(mus_p1) - (prod_p1 >>> GAIN_SHIFT);
  assign sat_c  = sat16(diff_c);

  // ---- stage p2: output register, done strobe and clip qualifier at end of SUM
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      done_out   <= 1'b0;
      clip_out   <= 1'b0;
      signal_out <= '0;
    end else begin
      done_out <= (state == SUM);
      clip_out <= (state == SUM) ? sat_c[16] : 1'b0;
      if (state == SUM) signal_out <= sat_c[15:0];
    end
  end

`ifdef CLIP_COUNT_EN
  // Saturating count of clipped output samples
  always_ff @(posedge clk_in) begin
    if (reset_in)
      clip_count_out <= '0;
    else if ((state == SUM) && sat_c[16] && (clip_count_out != 16'hFFFF))
      clip_count_out <= clip_count_out + 16'd1;
  end
`endif

endmodule

// File: tb/tb_anc_output_mixer.sv
// Directed bench for anc_output_mixer (GAIN_SHIFT=6, RAMP_EVERY=1).
module tb_anc_output_mixer;

  logic               clk_in = 1'b0;
  logic               reset_in;
  logic               anc_en_in;
  logic               ambient_valid_in;
  logic signed [15:0] ambient_in;
  logic               music_valid_in;
  logic signed [15:0] music_in;
  logic               done_out;
  logic signed [15:0] signal_out;
  logic               clip_out;
  logic               overrun_out;
`ifdef CLIP_COUNT_EN
  logic [15:0]        clip_count_out;
  int                 exp_cc = 0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  anc_output_mixer #(.GAIN_SHIFT(6), .RAMP_EVERY(1)) dut (
    .clk_in           (clk_in),
    .reset_in         (reset_in),
    .anc_en_in        (anc_en_in),
    .ambient_valid_in (ambient_valid_in),
    .ambient_in       (ambient_in),
    .music_valid_in   (music_valid_in),
    .music_in         (music_in),
    .done_out         (done_out),
    .signal_out       (signal_out),
    .clip_out         (clip_out),
    .overrun_out      (overrun_out)
`ifdef CLIP_COUNT_EN
    ,
    .clip_count_out   (clip_count_out)
`endif
  );

  typedef struct {
    logic signed [15:0] mus;
    logic signed [15:0] amb;
    logic signed [15:0] exp_sig;
    logic               exp_clip;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Strobe both inputs together, then wait (bounded) for done_out.
  task automatic run_pair(input logic signed [15:0] m, input logic signed [15:0] a,
                          output logic signed [15:0] s, output logic c, output int lat);
    music_valid_in   = 1'b1;
    music_in         = m;
    ambient_valid_in = 1'b1;
    ambient_in       = a;
    tick();
    music_valid_in   = 1'b0;
    ambient_valid_in = 1'b0;
    lat = -1;
    s   = '0;
    c   = 1'b0;
    for (int i = 1; i <= 8 && lat < 0; i++) begin
      tick();
      if (done_out) begin
        lat = i;
        s   = signal_out;
        c   = clip_out;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic signed [15:0] s;
    logic               c;
    int                 lat;
    logic               seen;

    tbl[0] = '{16'sd1000,   16'sd300,    16'sd700,    1'b0};
    tbl[1] = '{-16'sd30000, 16'sd10000,  -16'sd32768, 1'b1};
    tbl[2] = '{16'sd30000,  -16'sd10000, 16'sd32767,  1'b1};
    tbl[3] = '{16'sd0,      -16'sd32768, 16'sd32767,  1'b1};
    tbl[4] = '{16'sd32767,  16'sd0,      16'sd32767,  1'b0};
    tbl[5] = '{-16'sd32768, 16'sd0,      -16'sd32768, 1'b0};
    tbl[6] = '{-16'sd1,     16'sd32767,  -16'sd32768, 1'b0};
    tbl[7] = '{16'sd12345,  16'sd12345,  16'sd0,      1'b0};

    reset_in = 1'b1; anc_en_in = 1'b0;
    ambient_valid_in = 1'b0; ambient_in = '0;
    music_valid_in = 1'b0; music_in = '0;
    tick(); tick();
    reset_in = 1'b0;
    chk("reset_signal", signal_out, 0);
    chk("reset_done", done_out, 0);
    chk("reset_clip", clip_out, 0);
    chk("reset_overrun", overrun_out, 0);
`ifdef CLIP_COUNT_EN
    chk("reset_clip_count", clip_count_out, 0);
`endif

    // Gain 0: output equals music; done exactly 3 cycles after the completing strobe
    music_valid_in = 1'b1; music_in = 16'sd1000; tick();
    music_valid_in = 1'b0; tick();
    ambient_valid_in = 1'b1; ambient_in = 16'sd5000; tick();
    ambient_valid_in = 1'b0;
    tick(); chk("t1_done_early", done_out, 0);
    tick(); chk("t1_done_early2", done_out, 0);
    tick();
    chk("t1_done", done_out, 1);
    chk("t1_signal", signal_out, 1000);
    chk("t1_clip", clip_out, 0);

    // Ramp up with floor behaviour at small gains
    anc_en_in = 1'b1;
    run_pair(16'sd0, 16'sd6400, s, c, lat);
    chk("ramp_k0", s, 0);
    chk("ramp_k0_lat", lat, 3);
    run_pair(16'sd0, -16'sd1, s, c, lat);
    chk("floor_neg", s, 1);
    run_pair(16'sd0, 16'sd63, s, c, lat);
    chk("floor_pos", s, -1);
    for (int k = 3; k < 70; k++) begin
      run_pair(16'sd0, 16'sd6400, s, c, lat);
      chk($sformatf("ramp_up_k%0d", k), s, -100 * ((k < 64) ? k : 64));
    end

    // Ramp down back to zero cancellation
    anc_en_in = 1'b0;
    for (int j = 0; j <= 64; j++) begin
      run_pair(16'sd0, 16'sd6400, s, c, lat);
      chk($sformatf("ramp_dn_j%0d", j), s, -100 * (64 - j));
    end

    // Bring gain back to full scale
    anc_en_in = 1'b1;
    for (int k = 0; k < 64; k++) run_pair(16'sd0, 16'sd0, s, c, lat);

    // Table at full gain: out = sat(music - ambient)
    for (int i = 0; i < 8; i++) begin
      run_pair(tbl[i].mus, tbl[i].amb, s, c, lat);
      chk($sformatf("tbl%0d_lat", i), lat, 3);
      chk($sformatf("tbl%0d_signal", i), s, tbl[i].exp_sig);
      chk($sformatf("tbl%0d_clip", i), c, tbl[i].exp_clip);
`ifdef CLIP_COUNT_EN
      if (tbl[i].exp_clip) exp_cc++;
`endif
      if (tbl[i].exp_clip) begin
        tick();
        chk($sformatf("tbl%0d_clip_after", i), clip_out, 0);
      end
    end
`ifdef CLIP_COUNT_EN
    chk("clip_count", clip_count_out, exp_cc);
`endif

    // Overrun: second ambient replaces the first; strobes during consume/MULT survive
    chk("overrun_before", overrun_out, 0);
    ambient_valid_in = 1'b1; ambient_in = 16'sd100; tick();
    ambient_in = 16'sd200; tick();
    ambient_valid_in = 1'b0;
    chk("overrun_set", overrun_out, 1);
    music_valid_in = 1'b1; music_in = 16'sd0; tick();
    music_valid_in = 1'b0;
    ambient_valid_in = 1'b1; ambient_in = 16'sd500; tick();
    ambient_valid_in = 1'b0;
    music_valid_in = 1'b1; music_in = 16'sd1000; tick();
    music_valid_in = 1'b0;
    tick();
    chk("ovr_done", done_out, 1);
    chk("ovr_signal", signal_out, -200);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (done_out) begin
        seen = 1'b1;
        chk("ovr_next_signal", signal_out, 500);
      end
    end
    chk("ovr_next_done", seen, 1);
    chk("overrun_sticky", overrun_out, 1);

    // Reset while a pair is in flight: dropped, state cleared
    music_valid_in = 1'b1; music_in = 16'sd1000;
    ambient_valid_in = 1'b1; ambient_in = 16'sd100; tick();
    music_valid_in = 1'b0; ambient_valid_in = 1'b0;
    reset_in = 1'b1; tick();
    reset_in = 1'b0;
    chk("rst_signal", signal_out, 0);
    chk("rst_overrun", overrun_out, 0);
`ifdef CLIP_COUNT_EN
    chk("rst_clip_count", clip_count_out, 0);
`endif
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done_out) seen = 1'b1;
    end
    chk("rst_no_done", seen, 0);
    ambient_valid_in = 1'b1; ambient_in = 16'sd5000; tick();
    ambient_valid_in = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done_out) seen = 1'b1;
    end
    chk("rst_flags_clear", seen, 0);
    music_valid_in = 1'b1; music_in = 16'sd1000; tick();
    music_valid_in = 1'b0;
    tick(); tick(); tick();
    chk("rst_pair_done", done_out, 1);
    chk("rst_gain_zero", signal_out, 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
